// File: rtl/twotoone_demux_stream.sv
// Registered 1-to-2 stream demultiplexer with a one-entry valid/ready register per output.
// Define DEMUX_CNT_EN to add per-output delivery counters (cnt0/cnt1).
module twotoone_demux_stream #(
    parameter int unsigned DATA_W  = 7
`ifdef DEMUX_CNT_EN
    ,
    parameter int unsigned COUNT_W = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              s,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [COUNT_W-1:0] cnt0,
    output logic [COUNT_W-1:0] cnt1
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t            r_st0, r_st1;
    state_t            w_st0_nxt, w_st1_nxt;
    logic [DATA_W-1:0] r_data0, r_data1;
    logic              w_load0, w_load1;
    logic              w_room0, w_room1;

    assign out0_valid = (r_st0 == S_FULL);
    assign out1_valid = (r_st1 == S_FULL);
    assign out0_data  = r_data0;
    assign out1_data  = r_data1;

    // A slot can take a word if it is empty or its current word leaves this cycle.
    assign w_room0  = ~out0_valid | out0_ready;
    assign w_room1  = ~out1_valid | out1_ready;
    assign in_ready = ~rst & (s ? w_room1 : w_room0);
    assign w_load0  = in_valid & in_ready & ~s;
    assign w_load1  = in_valid & in_ready & s;

    always_comb begin
        w_st0_nxt = r_st0;
        w_st1_nxt = r_st1;
        if (r_st0 == S_EMPTY) begin
            if (w_load0) w_st0_nxt = S_FULL;
        end else if (out0_ready && !w_load0) begin
            w_st0_nxt = S_EMPTY;
        end
        if (r_st1 == S_EMPTY) begin
            if (w_load1) w_st1_nxt = S_FULL;
        end else if (out1_ready && !w_load1) begin
            w_st1_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st0   <= S_EMPTY;
            r_st1   <= S_EMPTY;
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            r_st0 <= w_st0_nxt;
            r_st1 <= w_st1_nxt;
            if (w_load0) r_data0 <= in_data;
            if (w_load1) r_data1 <= in_data;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [COUNT_W-1:0] r_cnt0, r_cnt1;

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) r_cnt0 <= r_cnt0 + 1'b1;
            if (out1_valid && out1_ready) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_twotoone_demux_stream.sv
// Self-checking bench for twotoone_demux_stream: directed vector table, scoreboard
// queues per output, randomized traffic and (with DEMUX_CNT_EN) counter wrap checks.
module tb_twotoone_demux_stream;

    localparam int DATA_W  = 7;
    localparam int COUNT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              s;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out1_valid;
    logic              out1_ready;
`ifdef DEMUX_CNT_EN
    logic [COUNT_W-1:0] cnt0, cnt1;
`endif

    twotoone_demux_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1_data (out1_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0]  q0[$];
    logic [DATA_W-1:0]  q1[$];
    logic [COUNT_W-1:0] m_cnt0 = '0;
    logic [COUNT_W-1:0] m_cnt1 = '0;
    logic               last_stall = 1'b0;

    typedef struct {
        logic              v;
        logic              sel;
        logic [DATA_W-1:0] d;
        logic              r0;
        logic              r1;
        logic              rdy;
        logic              v0;
        logic              v1;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [DATA_W-1:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        s          = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // One clock: checks handshake-visible state at the negedge, updates the scoreboard,
    // then returns 1 time unit after the following posedge.
    task automatic tick();
        logic              acc, h0, h1, exp_rdy;
        logic [DATA_W-1:0] e;
        @(negedge clk);
        exp_rdy = !rst && (s ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
        chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
`ifdef DEMUX_CNT_EN
        chk("cnt0", 32'(cnt0), 32'(m_cnt0));
        chk("cnt1", 32'(cnt1), 32'(m_cnt1));
`endif
        h0  = out0_valid & out0_ready;
        h1  = out1_valid & out1_ready;
        acc = in_valid & in_ready;
        last_stall = in_valid & ~in_ready;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_cnt0 = '0;
            m_cnt1 = '0;
        end else begin
            if (h0) begin
                m_cnt0++;
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    chk("out0_data", 32'(out0_data), 32'(e));
                end
            end
            if (h1) begin
                m_cnt1++;
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("out1_data", 32'(out1_data), 32'(e));
                end
            end
            if (acc) begin
                if (s) q1.push_back(in_data);
                else   q0.push_back(in_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // v  s  d      r0 r1 rdy v0 v1 d0     d1
        tbl[0] = '{1'b1, 1'b0, 7'h3F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 7'h00};
        tbl[1] = '{1'b1, 1'b1, 7'h06, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'h3F, 7'h00};
        tbl[2] = '{1'b1, 1'b0, 7'h5B, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7'h3F, 7'h06};
        tbl[3] = '{1'b1, 1'b0, 7'h5B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'h3F, 7'h06};
        tbl[4] = '{1'b1, 1'b1, 7'h4F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'h5B, 7'h06};
        tbl[5] = '{1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'h5B, 7'h4F};
        tbl[6] = '{1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h5B, 7'h4F};

        // Reset held for two cycles with a word offered.
        rst = 1'b1;
        drive(1'b1, 1'b0, 7'h11, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out0_valid", 32'(out0_valid), 32'(0));
        chk("rst_out1_valid", 32'(out1_valid), 32'(0));
        chk("rst_out0_data", 32'(out0_data), 32'(0));
        chk("rst_out1_data", 32'(out1_data), 32'(0));

        // Directed vectors: route, stall, zero-bubble replace, independence, drain, hold.
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
            #3;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_out0_valid", i), 32'(out0_valid), 32'(tbl[i].v0));
            chk($sformatf("vec%0d_out1_valid", i), 32'(out1_valid), 32'(tbl[i].v1));
            chk($sformatf("vec%0d_out0_data", i), 32'(out0_data), 32'(tbl[i].d0));
            chk($sformatf("vec%0d_out1_data", i), 32'(out1_data), 32'(tbl[i].d1));
            tick();
        end

        // Back-to-back streaming to out0.
        for (int w = 1; w <= 8; w++) begin
            drive(1'b1, 1'b0, 7'(w), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        tick();
        chk("stream_drained", 32'(q0.size()), 32'(0));

        // Random traffic obeying the hold-while-stalled producer rule.
        for (int c = 0; c < 400; c++) begin
            if (!last_stall) begin
                in_valid = 1'($urandom_range(0, 3) != 0);
                s        = 1'($urandom_range(0, 1));
                in_data  = 7'($urandom);
            end
            out0_ready = 1'($urandom_range(0, 2) != 0);
            out1_ready = 1'($urandom_range(0, 2) != 0);
            tick();
        end
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b1);
        tick();
        tick();

`ifdef DEMUX_CNT_EN
        // Counter wrap: 257 deliveries on out1 after a fresh reset.
        rst = 1'b1;
        drive(1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 1'b1, 7'(i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 1'b1, 7'h00, 1'b0, 1'b1);
        tick();
        chk("wrap_cnt1", 32'(cnt1), 32'(1));
        chk("wrap_cnt0", 32'(cnt0), 32'(0));
`endif

        // Mid-operation reset with both outputs full.
        drive(1'b1, 1'b0, 7'h2A, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 7'h55, 1'b0, 1'b0);
        tick();
        chk("full_out0_valid", 32'(out0_valid), 32'(1));
        chk("full_out1_valid", 32'(out1_valid), 32'(1));
        chk("full_out0_data", 32'(out0_data), 32'(7'h2A));
        chk("full_out1_data", 32'(out1_data), 32'(7'h55));
        rst = 1'b1;
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        chk("midrst_out0_valid", 32'(out0_valid), 32'(0));
        chk("midrst_out1_valid", 32'(out1_valid), 32'(0));
        chk("midrst_out0_data", 32'(out0_data), 32'(0));
        chk("midrst_out1_data", 32'(out1_data), 32'(0));
`ifdef DEMUX_CNT_EN
        chk("midrst_cnt0", 32'(cnt0), 32'(0));
        chk("midrst_cnt1", 32'(cnt1), 32'(0));
`endif
        drive(1'b0, 1'b0, 7'h00, 1'b1, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
